// File: rtl/issue_unit.sv
// issue_unit: round-robin issue scheduler for the int, ld/st, mult and div
// queues, with a CDB reservation shift register built from fixed latencies.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_*_ready             queue head ready (int, ldst, mult, div)
//   o_*_rd                pop/issue strobe per queue (one-hot or zero)
//   o_issue_valid         any rd strobe high
//   o_cdb_valid/o_cdb_src CDB owner this cycle (0 int, 1 ldst, 2 mult, 3 div)
//   o_div_busy            non-pipelined divider occupied
module issue_unit #(
    parameter int INT_LAT  = 1,
    parameter int LDST_LAT = 2,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_int_ready,
    input  logic       i_ldst_ready,
    input  logic       i_mult_ready,
    input  logic       i_div_ready,
    output logic       o_int_rd,
    output logic       o_ldst_rd,
    output logic       o_mult_rd,
    output logic       o_div_rd,
    output logic       o_issue_valid,
    output logic       o_cdb_valid,
    output logic [1:0] o_cdb_src,
    output logic       o_div_busy
);

    localparam int CW = $clog2(DIV_LAT + 1);

    // Slot k holds the completion that reaches the CDB k cycles from now.
    logic [DIV_LAT:0]      r_sv;
    logic [DIV_LAT:0][1:0] r_ss;
    logic [1:0]            r_ptr;
    logic [CW-1:0]         r_cnt;

    logic [3:0] w_elig;
    logic [3:0] w_gnt;
    logic [1:0] w_win;
    logic [1:0] w_idx;
    logic       w_any;

    // A unit of latency L may issue only if the slot that will shift into
    // S[L-1] this edge (currently S[L]) is free.
    assign w_elig[0] = i_int_ready  & ~r_sv[INT_LAT];
    assign w_elig[1] = i_ldst_ready & ~r_sv[LDST_LAT];
    assign w_elig[2] = i_mult_ready & ~r_sv[MULT_LAT];
    assign w_elig[3] = i_div_ready  & ~r_sv[DIV_LAT] & (r_cnt == '0);

    always_comb begin
        w_win = r_ptr;
        w_idx = r_ptr;
        w_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_any && w_elig[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        w_gnt = 4'b0000;
        if (w_any && !i_rst) begin
            w_gnt = 4'b0001 << w_win;
        end
    end

    assign o_int_rd      = w_gnt[0];
    assign o_ldst_rd     = w_gnt[1];
    assign o_mult_rd     = w_gnt[2];
    assign o_div_rd      = w_gnt[3];
    assign o_issue_valid = |w_gnt;
    assign o_cdb_valid   = r_sv[0];
    assign o_cdb_src     = r_ss[0];
    assign o_div_busy    = (r_cnt != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sv  <= '0;
            r_ss  <= '0;
            r_ptr <= 2'd0;
            r_cnt <= '0;
        end else begin
            r_sv <= {1'b0, r_sv[DIV_LAT:1]};
            r_ss <= {2'b00, r_ss[DIV_LAT:1]};
            if (w_gnt[0]) begin
                r_sv[INT_LAT-1] <= 1'b1;
                r_ss[INT_LAT-1] <= 2'd0;
            end
            if (w_gnt[1]) begin
                r_sv[LDST_LAT-1] <= 1'b1;
                r_ss[LDST_LAT-1] <= 2'd1;
            end
            if (w_gnt[2]) begin
                r_sv[MULT_LAT-1] <= 1'b1;
                r_ss[MULT_LAT-1] <= 2'd2;
            end
            if (w_gnt[3]) begin
                r_sv[DIV_LAT-1] <= 1'b1;
                r_ss[DIV_LAT-1] <= 2'd3;
            end
            if (w_any) begin
                r_ptr <= w_win + 2'd1;
            end
            if (w_gnt[3]) begin
                r_cnt <= CW'(DIV_LAT - 1);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: directed and random stimulus against a completion-calendar
// model of the issue scheduler, plus literal checks of hand-derived cycles.
module tb_issue_unit;

    localparam int DIV = 8;
    int LAT[4] = '{1, 2, 4, 8};

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] rdy = 4'h0;
    logic       o_int_rd, o_ldst_rd, o_mult_rd, o_div_rd;
    logic       o_issue_valid, o_cdb_valid, o_div_busy;
    logic [1:0] o_cdb_src;

    int n_tests = 0;
    int n_fail  = 0;

    issue_unit dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_int_ready  (rdy[0]),
        .i_ldst_ready (rdy[1]),
        .i_mult_ready (rdy[2]),
        .i_div_ready  (rdy[3]),
        .o_int_rd     (o_int_rd),
        .o_ldst_rd    (o_ldst_rd),
        .o_mult_rd    (o_mult_rd),
        .o_div_rd     (o_div_rd),
        .o_issue_valid(o_issue_valid),
        .o_cdb_valid  (o_cdb_valid),
        .o_cdb_src    (o_cdb_src),
        .o_div_busy   (o_div_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [3:0] rdv();
        return {o_div_rd, o_mult_rd, o_ldst_rd, o_int_rd};
    endfunction

    // Model: a calendar of which unit owns the CDB at each absolute cycle.
    bit m_bv[int];
    int m_bs[int];
    int m_ptr  = 0;
    int m_last = -100;
    int m_cyc  = 0;

    always @(negedge i_clk) begin
        int win;
        int u;
        logic [3:0] e_rd;
        logic e_cv;
        logic [1:0] e_cs;
        logic e_bz;
        if (i_rst) begin
            chk("rst_rd", 32'(rdv()), 0);
            chk("rst_cdb_valid", 32'(o_cdb_valid), 0);
            chk("rst_div_busy", 32'(o_div_busy), 0);
            m_bv.delete();
            m_bs.delete();
            m_ptr  = 0;
            m_last = -100;
            m_cyc  = 0;
        end else begin
            win = -1;
            for (int i = 0; i < 4; i++) begin
                u = (m_ptr + i) % 4;
                if (win < 0 && rdy[u] && !m_bv.exists(m_cyc + LAT[u]) &&
                    (u != 3 || m_cyc >= m_last + DIV))
                    win = u;
            end
            e_rd = (win < 0) ? 4'h0 : 4'(1 << win);
            e_cv = m_bv.exists(m_cyc);
            e_cs = e_cv ? 2'(m_bs[m_cyc]) : 2'd0;
            e_bz = (m_cyc > m_last) && (m_cyc < m_last + DIV);
            chk("rd", 32'(rdv()), 32'(e_rd));
            chk("issue_valid", 32'(o_issue_valid), 32'(e_rd != 0));
            chk("cdb_valid", 32'(o_cdb_valid), 32'(e_cv));
            chk("cdb_src", 32'(o_cdb_src), 32'(e_cs));
            chk("div_busy", 32'(o_div_busy), 32'(e_bz));
            if (win >= 0) begin
                m_bv[m_cyc + LAT[win]] = 1'b1;
                m_bs[m_cyc + LAT[win]] = win;
                m_ptr = (win + 1) % 4;
                if (win == 3) m_last = m_cyc;
            end
            if (m_bv.exists(m_cyc)) begin
                m_bv.delete(m_cyc);
                m_bs.delete(m_cyc);
            end
            m_cyc++;
        end
    end

    logic [3:0] g[64];
    logic       cv[64];
    logic [1:0] cs[64];
    logic       bz[64];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cap(input int c);
        @(negedge i_clk);
        #1;
        g[c]  = rdv();
        cv[c] = o_cdb_valid;
        cs[c] = o_cdb_src;
        bz[c] = o_div_busy;
        tick();
    endtask

    // Returns at the start of cycle 0 after release.
    task automatic do_reset();
        tick();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        int n;
        // Reset with all ready, then round-robin from int.
        rdy = 4'hF;
        tick();
        @(negedge i_clk);
        #1;
        chk("lit_rst_rd", 32'(rdv()), 0);
        chk("lit_rst_cdb", 32'(o_cdb_valid), 0);
        tick();
        i_rst = 1'b0;
        for (int c = 0; c < 12; c++) cap(c);
        chk("s1_g0", 32'(g[0]), 1);
        chk("s1_g1", 32'(g[1]), 2);
        chk("s1_g2", 32'(g[2]), 4);
        chk("s1_g3", 32'(g[3]), 8);
        chk("s1_g4", 32'(g[4]), 1);
        chk("s1_cdb1", 32'({cv[1], cs[1]}), 32'h4);
        chk("s1_cdb3", 32'({cv[3], cs[3]}), 32'h5);
        chk("s1_cdb5", 32'({cv[5], cs[5]}), 32'h4);
        chk("s1_cdb6", 32'({cv[6], cs[6]}), 32'h6);
        chk("s1_cdb11", 32'({cv[11], cs[11]}), 32'h7);

        // Mult then int: int blocked by the mult slot at c3.
        do_reset();
        rdy = 4'b0100;
        cap(0);
        rdy = 4'b0000;
        cap(1);
        cap(2);
        rdy = 4'b0001;
        cap(3);
        cap(4);
        rdy = 4'b0000;
        cap(5);
        chk("s2_g0", 32'(g[0]), 4);
        chk("s2_g3", 32'(g[3]), 0);
        chk("s2_g4", 32'(g[4]), 1);
        chk("s2_cdb4", 32'({cv[4], cs[4]}), 32'h6);
        chk("s2_cdb5", 32'({cv[5], cs[5]}), 32'h4);

        // Divider alone, ready held high.
        do_reset();
        rdy = 4'b1000;
        for (int c = 0; c < 17; c++) cap(c);
        chk("s3_g0", 32'(g[0]), 8);
        chk("s3_g7", 32'(g[7]), 0);
        chk("s3_g8", 32'(g[8]), 8);
        chk("s3_g16", 32'(g[16]), 8);
        chk("s3_bz0", 32'(bz[0]), 0);
        chk("s3_bz1", 32'(bz[1]), 1);
        chk("s3_bz7", 32'(bz[7]), 1);
        chk("s3_bz8", 32'(bz[8]), 0);
        chk("s3_cdb8", 32'({cv[8], cs[8]}), 32'h7);
        chk("s3_cdb16", 32'({cv[16], cs[16]}), 32'h7);

        // All ready for 40 cycles.
        do_reset();
        rdy = 4'hF;
        repeat (40) tick();

        // Reset mid-stream with mult and div in flight.
        do_reset();
        rdy = 4'b0100;
        cap(0);
        rdy = 4'b1000;
        cap(1);
        rdy = 4'hF;
        i_rst = 1'b1;
        @(negedge i_clk);
        #1;
        chk("s5_rst_rd", 32'(rdv()), 0);
        chk("s5_rst_cdb", 32'(o_cdb_valid), 0);
        tick();
        tick();
        i_rst = 1'b0;
        cap(0);
        rdy = 4'b0000;
        for (int c = 1; c < 15; c++) cap(c);
        chk("s5_g0", 32'(g[0]), 1);
        chk("s5_cdb1", 32'({cv[1], cs[1]}), 32'h4);
        n = 0;
        for (int c = 2; c < 15; c++) n += int'(cv[c]);
        chk("s5_no_stale_cdb", 32'(n), 0);

        // Single ldst then idle; pointer resumes at mult.
        do_reset();
        rdy = 4'b0010;
        cap(0);
        rdy = 4'b0000;
        for (int c = 1; c < 11; c++) cap(c);
        rdy = 4'hF;
        cap(11);
        chk("s6_g0", 32'(g[0]), 2);
        chk("s6_cdb2", 32'({cv[2], cs[2]}), 32'h5);
        n = 0;
        for (int c = 1; c < 11; c++) n += int'(cv[c]);
        chk("s6_one_pulse", 32'(n), 1);
        chk("s6_g11", 32'(g[11]), 4);

        // Random readies with occasional reset.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rdy = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) begin
                i_rst = 1'b1;
                tick();
                i_rst = 1'b0;
            end else begin
                tick();
            end
        end
        rdy = 4'h0;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
